// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: issues MULT/MULTU/DIV/DIVU to the multi-cycle units, stalls EX
// while they run, and performs exactly one HI/LO write per instruction.
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        ext_stall,
    input  logic        flush,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        stallreq,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [31:0] opa, opb;
    logic        sgn;
    logic [63:0] res;
    logic        first;

    logic issue, is_mul, is_div, div_zero;

    assign issue    = op_valid && !flush;
    assign is_mul   = (op == 3'd0) || (op == 3'd1);
    assign is_div   = (op == 3'd2) || (op == 3'd3);
    assign div_zero = (src2 == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            sgn   <= 1'b0;
            res   <= '0;
            first <= 1'b0;
        end else begin
            state <= state_nxt;
            // Marks the single DONE cycle that is allowed to write HI/LO.
            first <= (state_nxt == DONE) && (state != DONE);
            case (state)
                IDLE: begin
                    if (issue && is_mul) begin
                        opa <= src1;
                        opb <= src2;
                        sgn <= (op == 3'd0);
                        cnt <= CNT_INIT;
                    end else if (issue && is_div) begin
                        opa <= src1;
                        opb <= src2;
                        sgn <= (op == 3'd2);
                        if (div_zero) res <= {src1, 32'hFFFF_FFFF};
                    end
                end
                MUL_WAIT: begin
                    if (cnt != '0) cnt <= cnt - 4'd1;
                    else           res <= mul_result;
                end
                DIV_WAIT: begin
                    if (div_ready) res <= div_result;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        mul_signed  = 1'b0;
        mul_ina     = '0;
        mul_inb     = '0;
        div_start   = 1'b0;
        div_signed  = 1'b0;
        div_opdata1 = '0;
        div_opdata2 = '0;
        div_annul   = 1'b0;
        stallreq    = 1'b0;
        hi_we       = 1'b0;
        lo_we       = 1'b0;
        hi_wdata    = '0;
        lo_wdata    = '0;
        busy        = 1'b0;
        if (resetn) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (issue) begin
                        if (is_mul) begin
                            stallreq  = 1'b1;
                            state_nxt = MUL_WAIT;
                        end else if (is_div) begin
                            stallreq  = 1'b1;
                            state_nxt = div_zero ? DONE : DIV_WAIT;
                        end else if (op == 3'd4) begin
                            hi_we    = !ext_stall;
                            hi_wdata = ext_stall ? '0 : src1;
                        end else if (op == 3'd5) begin
                            lo_we    = !ext_stall;
                            lo_wdata = ext_stall ? '0 : src1;
                        end
                    end
                end
                MUL_WAIT: begin
                    mul_ina    = opa;
                    mul_inb    = opb;
                    mul_signed = sgn;
                    stallreq   = 1'b1;
                    if (flush)            state_nxt = IDLE;
                    else if (cnt == '0)   state_nxt = DONE;
                end
                DIV_WAIT: begin
                    div_start   = !div_ready;
                    div_opdata1 = opa;
                    div_opdata2 = opb;
                    div_signed  = sgn;
                    stallreq    = 1'b1;
                    if (flush) begin
                        div_annul = 1'b1;
                        state_nxt = IDLE;
                    end else if (div_ready) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (first && !flush) begin
                        hi_we    = 1'b1;
                        lo_we    = 1'b1;
                        hi_wdata = res[63:32];
                        lo_wdata = res[31:0];
                    end
                    if (!ext_stall) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the multi-cycle multiply/divide resources beside the EX stage. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request from EX and drives the `mul` and `div` units. While an operation is in flight it raises a stall request toward the pipeline controller. It produces exactly one HI/LO register-file write per instruction, and handles divide-by-zero, flush and external pipeline stall.

## Interface
Parameters:
- `MUL_LAT`, default 2: fixed multiplier latency in cycles from operands stable to `mul_result` valid. Legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `op_valid`  in  1  EX holds a HI/LO-class instruction this cycle.
- `op`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are ignored.
- `src1`, `src2`  in  32  rs / rt operand values; held stable by EX while `stallreq`=1.
- `ext_stall`  in  1  EX is held by another stall source this cycle.
- `flush`  in  1  kill the current EX instruction.
- `mul_signed`  out  1  multiplier signed mode.
- `mul_ina`, `mul_inb`  out  32  multiplier operands.
- `mul_result`  in  64  multiplier product.
- `div_start`  out  1  divider start, level-held until ready.
- `div_signed`  out  1  divider signed mode.
- `div_opdata1`, `div_opdata2`  out  32  dividend, divisor.
- `div_annul`  out  1  one-cycle abort pulse to the divider.
- `div_result`  in  64  {remainder, quotient}.
- `div_ready`  in  1  divider result valid.
- `stallreq`  out  1  stall request to the pipeline controller.
- `hi_we`, `lo_we`  out  1  HI / LO write enables.
- `hi_wdata`, `lo_wdata`  out  32  HI / LO write data.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE. Operands, sign mode and result are held in registers `opa`, `opb`, `sgn` and `res[63:0]`.
- **IDLE** (issue happens when `op_valid` && !`flush`):
  - MULT/MULTU: `stallreq`=1 combinationally. Latch `src1`/`src2`/`sgn` (MULT=1), load `cnt`=MUL_LAT-1, go to MUL_WAIT.
  - DIV/DIVU, `src2`≠0: `stallreq`=1. Latch operands and `sgn` (DIV=1), go to DIV_WAIT.
  - DIV/DIVU, `src2`=0: `stallreq`=1. Set `res`={src1, 32'hFFFF_FFFF} and go to DONE; the divider is not started.
  - MTHI/MTLO: no stall, no state change. `hi_we` (resp. `lo_we`)=1 in the same cycle with data=`src1`, gated by !`ext_stall`. The write occurs once, in the cycle EX advances.
- **MUL_WAIT**:
  - `mul_ina`=`opa`, `mul_inb`=`opb`, `mul_signed`=`sgn`, `stallreq`=1.
  - `cnt` decrements each cycle. At `cnt`=0, `res`←`mul_result` and go to DONE.
- **DIV_WAIT**:
  - `div_start`=1, `div_opdata1/2`=`opa`/`opb`, `div_signed`=`sgn`, `stallreq`=1.
  - On `div_ready`=1: `res`←`div_result`, `div_start`=0 in that same cycle, go to DONE.
- **DONE**:
  - `stallreq`=0. `hi_we`=`lo_we`=1 only in the first DONE cycle, with `hi_wdata`=`res[63:32]` and `lo_wdata`=`res[31:0]`.
  - Stay in DONE while `ext_stall`=1, with no further writes and no reissue. Go to IDLE on the first cycle with `ext_stall`=0.
- **flush**:
  - In MUL_WAIT/DIV_WAIT: go to IDLE next edge with no HI/LO write. In DIV_WAIT, `div_annul`=1 for that cycle.
  - In IDLE: suppresses issue and MTHI/MTLO writes.
  - In DONE: suppresses the write if it is the first DONE cycle.
- When not in their active state, all multiplier/divider driving outputs are 0.

## Timing
- Reset (`resetn`=0 at an edge): state=IDLE, `cnt`=0, `res`=0, operand registers=0. Reset has priority over every input, including mid-operation. While `resetn`=0, every output is 0.
- MULT issued in cycle T:
  - `stallreq`=1 in T..T+MUL_LAT, which is MUL_LAT+1 stall cycles.
  - DONE and the HI/LO write in cycle T+MUL_LAT+1.
- DIV issued in T:
  - `stallreq`=1 from T through the cycle `div_ready` is seen (Tr).
  - HI/LO write in Tr+1.
- DIV by zero issued in T: `stallreq`=1 in T only; write in T+1.
- MTHI/MTLO: write in the issue cycle, 0 added latency.
- Outputs `stallreq`, `hi_we`, `lo_we` and the data outputs are combinational from state plus inputs. There are no registered-output delays.

## Test plan
- Reset mid-MUL_WAIT: assert `resetn`=0 for one edge → `busy`=0, `stallreq`=0, no `hi_we`/`lo_we` at any point.
- MULT with MUL_LAT=2, src1=-3, src2=5 (model mul result `0xFFFFFFFF_FFFFFFF1`) → `stallreq` high for 3 cycles, then exactly one write of hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU 100/7, model divider ready 33 cycles after start → `div_start` held until ready, then one write of hi=2, lo=14; `stallreq` falls in the write cycle.
- DIV 5/0 → divider never started; hi=5, lo=0xFFFFFFFF written one cycle after issue.
- DIV with `flush` asserted at cycle 10 of DIV_WAIT → `div_annul` pulses for one cycle, state returns to IDLE, no write.
- MULTU completing while `ext_stall`=1 for 3 cycles → single write on the first DONE cycle, FSM stays in DONE, no reissue; return to IDLE when `ext_stall` drops.
- MTLO src1=0x1234 with `ext_stall`=1 then 0 → `lo_we` only in the unstalled cycle, `stallreq` never asserted.
